// File: rtl/instr_fetch_if.sv
// Byte-wide ROM port used by instr_fetch.
// The fetch side drives the address and two-phase trigger.
interface instr_fetch_if;
    logic [31:0] romAddr;
    logic        romTrigger;
    logic [7:0]  romData;
    logic        romReady;

    modport master (
        output romAddr,
        output romTrigger,
        input  romData,
        input  romReady
    );

    modport slave (
        input  romAddr,
        input  romTrigger,
        output romData,
        output romReady
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: four byte reads from the ROM port,
// assembled little-endian into one 32-bit instruction.
module instr_fetch #(
    parameter int unsigned GUARD_CYCLES = 2,
    parameter int unsigned TIMEOUT      = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pcIn,
    input  logic        fetchReq,
    input  logic        flush,
    output logic        fetchBusy,
    output logic [31:0] instrOut,
    output logic        instrValid,
    output logic        fetchErr,
    instr_fetch_if.master rom
);

    localparam logic [3:0]  GUARD_LD   = 4'(GUARD_CYCLES);
    localparam logic [15:0] TIMEOUT_LD = 16'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        GUARD,
        WAIT,
        DONE
    } state_t;

    state_t      state;
    logic [1:0]  k;
    logic [3:0]  gcnt;
    logic [15:0] tcnt;
    logic [31:0] asm_q;
    logic [31:0] asm_next;
    logic [1:0]  ready_q;
    logic        readySync;
    logic        unused_pc;

    assign readySync = ready_q[1];
    assign unused_pc = ^pcIn[1:0];

    always_comb begin
        asm_next = asm_q;
        asm_next[{k, 3'b000} +: 8] = rom.romData;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            k              <= 2'd0;
            gcnt           <= 4'd0;
            tcnt           <= 16'd0;
            asm_q          <= 32'd0;
            ready_q        <= 2'b00;
            fetchBusy      <= 1'b0;
            instrOut       <= 32'd0;
            instrValid     <= 1'b0;
            fetchErr       <= 1'b0;
            rom.romAddr    <= 32'd0;
            rom.romTrigger <= 1'b0;
        end else begin
            ready_q    <= {ready_q[0], rom.romReady};
            instrValid <= 1'b0;
            fetchErr   <= 1'b0;
            if (state != IDLE && flush) begin
                // Trigger level is kept; a late byte is absorbed by the next GUARD.
                state     <= IDLE;
                fetchBusy <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (fetchReq && !flush) begin
                            rom.romAddr <= {pcIn[31:2], 2'b00};
                            k           <= 2'd0;
                            fetchBusy   <= 1'b1;
                            state       <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        rom.romTrigger <= ~rom.romTrigger;
                        gcnt           <= GUARD_LD;
                        state          <= GUARD;
                    end
                    GUARD: begin
                        gcnt <= gcnt - 4'd1;
                        if (gcnt <= 4'd1) begin
                            tcnt  <= 16'd0;
                            state <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (readySync) begin
                            asm_q <= asm_next;
                            if (k == 2'd3) begin
                                // Publish with the last byte so valid lands in DONE.
                                instrOut   <= asm_next;
                                instrValid <= 1'b1;
                                state      <= DONE;
                            end else begin
                                k           <= k + 2'd1;
                                rom.romAddr <= {rom.romAddr[31:2], k + 2'd1};
                                state       <= ISSUE;
                            end
                        end else if ((tcnt + 16'd1) == TIMEOUT_LD) begin
                            fetchErr  <= 1'b1;
                            fetchBusy <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            tcnt <= tcnt + 16'd1;
                        end
                    end
                    DONE: begin
                        fetchBusy <= 1'b0;
                        state     <= IDLE;
                    end
                    default: begin
                        fetchBusy <= 1'b0;
                        state     <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a small byte ROM model.
// Runs with GUARD_CYCLES=2 and TIMEOUT=20.
module tb_instr_fetch;

    logic        clk;
    logic        reset;
    logic [31:0] pcIn;
    logic        fetchReq;
    logic        flush;
    logic        fetchBusy;
    logic [31:0] instrOut;
    logic        instrValid;
    logic        fetchErr;

    int vectors;
    int miscompares;

    instr_fetch_if rif();

    instr_fetch #(
        .GUARD_CYCLES(2),
        .TIMEOUT(20)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pcIn(pcIn),
        .fetchReq(fetchReq),
        .flush(flush),
        .fetchBusy(fetchBusy),
        .instrOut(instrOut),
        .instrValid(instrValid),
        .fetchErr(fetchErr),
        .rom(rif.master)
    );

    function automatic logic [7:0] rom_byte(input logic [31:0] a);
        case (a)
            32'h0000_0100: rom_byte = 8'h0D;
            32'h0000_0101: rom_byte = 8'hC0;
            32'h0000_0102: rom_byte = 8'hA0;
            32'h0000_0103: rom_byte = 8'hE1;
            32'h0000_0200: rom_byte = 8'h78;
            32'h0000_0201: rom_byte = 8'h56;
            32'h0000_0202: rom_byte = 8'h34;
            32'h0000_0203: rom_byte = 8'h12;
            32'hFFFF_FFFC: rom_byte = 8'hEF;
            32'hFFFF_FFFD: rom_byte = 8'hBE;
            32'hFFFF_FFFE: rom_byte = 8'hAD;
            32'hFFFF_FFFF: rom_byte = 8'hDE;
            default:       rom_byte = a[7:0] ^ 8'h5A;
        endcase
    endfunction

    assign rif.romData = rom_byte(rif.romAddr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Trigger edge monitor: counts toggles and logs the address at each.
    int          tog_cnt;
    logic        prev_trig;
    logic [31:0] addr_log [64];

    initial begin
        tog_cnt   = 0;
        prev_trig = 1'b0;
    end

    always @(negedge clk) begin
        if (rif.romTrigger !== prev_trig) begin
            addr_log[tog_cnt[5:0]] <= rif.romAddr;
            tog_cnt <= tog_cnt + 1;
        end
        prev_trig <= rif.romTrigger;
    end

    task automatic run_fetch(
        input  logic [31:0] pc,
        output int          v_cyc,
        output int          v_cnt,
        output int          e_cnt,
        output int          b_rise,
        output int          b_fall,
        output logic [31:0] word
    );
        v_cyc  = -1;
        v_cnt  = 0;
        e_cnt  = 0;
        b_rise = -1;
        b_fall = -1;
        pcIn     = pc;
        fetchReq = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) fetchReq = 1'b0;
            if (instrValid) begin
                v_cnt++;
                if (v_cyc < 0) v_cyc = n;
            end
            if (fetchErr) e_cnt++;
            if (fetchBusy && b_rise < 0) b_rise = n;
            if (!fetchBusy && b_rise >= 0 && b_fall < 0) b_fall = n;
        end
        word = instrOut;
    endtask

    task automatic test_reset();
        vectors++;
        if (rif.romAddr !== 32'd0) begin
            miscompares++;
            $display("FAIL rst_addr got %h want 0", rif.romAddr);
        end
        vectors++;
        if (rif.romTrigger !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_trig got %b want 0", rif.romTrigger);
        end
        vectors++;
        if (instrOut !== 32'd0) begin
            miscompares++;
            $display("FAIL rst_instr got %h want 0", instrOut);
        end
        vectors++;
        if ({instrValid, fetchBusy, fetchErr} !== 3'b000) begin
            miscompares++;
            $display("FAIL rst_flags got %b want 000",
                     {instrValid, fetchBusy, fetchErr});
        end
    endtask

    task automatic test_basic();
        int vc, vn, en, br, bf, t0;
        logic [31:0] w;
        t0 = tog_cnt;
        run_fetch(32'h100, vc, vn, en, br, bf, w);
        vectors++;
        if (w !== 32'hE1A0C00D) begin
            miscompares++;
            $display("FAIL basic_word got %h want e1a0c00d", w);
        end
        vectors++;
        if (vc !== 17) begin
            miscompares++;
            $display("FAIL basic_vcyc got %0d want 17", vc);
        end
        vectors++;
        if (vn !== 1 || en !== 0) begin
            miscompares++;
            $display("FAIL basic_pulses got v%0d e%0d want v1 e0", vn, en);
        end
        vectors++;
        if (br !== 1 || bf !== 18) begin
            miscompares++;
            $display("FAIL basic_busy got %0d/%0d want 1/18", br, bf);
        end
        vectors++;
        if (tog_cnt - t0 !== 4) begin
            miscompares++;
            $display("FAIL basic_toggles got %0d want 4", tog_cnt - t0);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (addr_log[6'(t0 + i)] !== 32'h100 + 32'(i)) begin
                miscompares++;
                $display("FAIL basic_addr%0d got %h want %h",
                         i, addr_log[6'(t0 + i)], 32'h100 + 32'(i));
            end
        end
    endtask

    task automatic test_unaligned();
        int vc, vn, en, br, bf, t0;
        logic [31:0] w;
        t0 = tog_cnt;
        run_fetch(32'h103, vc, vn, en, br, bf, w);
        vectors++;
        if (w !== 32'hE1A0C00D || vc !== 17) begin
            miscompares++;
            $display("FAIL unaligned got %h@%0d want e1a0c00d@17", w, vc);
        end
        vectors++;
        if (addr_log[6'(t0)] !== 32'h100) begin
            miscompares++;
            $display("FAIL unaligned_base got %h want 100",
                     addr_log[6'(t0)]);
        end
    endtask

    task automatic test_top_addr();
        int vc, vn, en, br, bf, t0;
        logic [31:0] w;
        t0 = tog_cnt;
        run_fetch(32'hFFFF_FFFC, vc, vn, en, br, bf, w);
        vectors++;
        if (w !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL top_word got %h want deadbeef", w);
        end
        vectors++;
        if (addr_log[6'(t0)] !== 32'hFFFF_FFFC ||
            addr_log[6'(t0 + 3)] !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL top_addr got %h..%h want fffffffc..ffffffff",
                     addr_log[6'(t0)], addr_log[6'(t0 + 3)]);
        end
    endtask

    task automatic test_flush();
        int vc, vn, en, br, bf, t0, vseen;
        logic [31:0] w, old;
        old   = instrOut;
        t0    = tog_cnt;
        vseen = 0;
        pcIn     = 32'h300;
        fetchReq = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) fetchReq = 1'b0;
            if (n == 9) flush = 1'b1;
            if (n == 10) flush = 1'b0;
            if (instrValid || fetchErr) vseen++;
        end
        vectors++;
        if (fetchBusy !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_idle got busy=%b want 0", fetchBusy);
        end
        vectors++;
        if (vseen !== 0 || instrOut !== old) begin
            miscompares++;
            $display("FAIL flush_hold got %h p%0d want %h p0",
                     instrOut, vseen, old);
        end
        vectors++;
        if (tog_cnt - t0 !== 2) begin
            miscompares++;
            $display("FAIL flush_toggles got %0d want 2", tog_cnt - t0);
        end
        run_fetch(32'h200, vc, vn, en, br, bf, w);
        vectors++;
        if (w !== 32'h12345678 || vc !== 17) begin
            miscompares++;
            $display("FAIL flush_refetch got %h@%0d want 12345678@17", w, vc);
        end
    endtask

    task automatic test_timeout();
        int ecyc, ecnt, vcnt, t0;
        logic [31:0] old;
        old  = instrOut;
        t0   = tog_cnt;
        ecyc = -1;
        ecnt = 0;
        vcnt = 0;
        pcIn     = 32'h100;
        fetchReq = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (n == 1) begin
                fetchReq     = 1'b0;
                rif.romReady = 1'b0;
            end
            if (fetchErr) begin
                ecnt++;
                if (ecyc < 0) ecyc = n;
            end
            if (instrValid) vcnt++;
            if (n == 24) begin
                vectors++;
                if (fetchBusy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL tmo_busy got %b want 0", fetchBusy);
                end
            end
        end
        vectors++;
        if (ecyc !== 24 || ecnt !== 1) begin
            miscompares++;
            $display("FAIL tmo_err got %0d@%0d want 1@24", ecnt, ecyc);
        end
        vectors++;
        if (vcnt !== 0 || instrOut !== old || tog_cnt - t0 !== 1) begin
            miscompares++;
            $display("FAIL tmo_side got v%0d %h t%0d want v0 %h t1",
                     vcnt, instrOut, tog_cnt - t0, old);
        end
        rif.romReady = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int vc, vn, en, br, bf;
        logic [31:0] w;
        pcIn     = 32'h100;
        fetchReq = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (n == 1) fetchReq = 1'b0;
            if (n == 9) rif.romReady = 1'b0;
        end
        vectors++;
        if (rif.romAddr !== 32'h102 || fetchBusy !== 1'b1) begin
            miscompares++;
            $display("FAIL rmid_pre got %h b%b want 102 b1",
                     rif.romAddr, fetchBusy);
        end
        #2 reset = 1'b1;
        #1;
        test_reset();
        @(negedge clk);
        rif.romReady = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_fetch(32'h100, vc, vn, en, br, bf, w);
        vectors++;
        if (w !== 32'hE1A0C00D || vc !== 17) begin
            miscompares++;
            $display("FAIL rmid_after got %h@%0d want e1a0c00d@17", w, vc);
        end
    endtask

    task automatic test_req_flush_idle();
        int t0, busy_seen;
        t0        = tog_cnt;
        busy_seen = 0;
        pcIn      = 32'h200;
        fetchReq  = 1'b1;
        flush     = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (fetchBusy) busy_seen++;
        end
        fetchReq = 1'b0;
        flush    = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (busy_seen !== 0 || tog_cnt - t0 !== 0) begin
            miscompares++;
            $display("FAIL reqflush got b%0d t%0d want b0 t0",
                     busy_seen, tog_cnt - t0);
        end
    endtask

    task automatic test_back_to_back();
        int v1, v2;
        logic [31:0] w1, w2;
        v1 = -1;
        v2 = -1;
        w1 = 32'd0;
        w2 = 32'd0;
        pcIn     = 32'h100;
        fetchReq = 1'b1;
        for (int n = 1; n <= 45; n++) begin
            @(negedge clk);
            if (n == 5) pcIn = 32'h200;
            if (instrValid) begin
                if (v1 < 0) begin
                    v1 = n;
                    w1 = instrOut;
                end else if (v2 < 0) begin
                    v2 = n;
                    w2 = instrOut;
                end
            end
        end
        fetchReq = 1'b0;
        repeat (25) @(negedge clk);
        vectors++;
        if (v1 !== 17 || w1 !== 32'hE1A0C00D) begin
            miscompares++;
            $display("FAIL b2b_first got %h@%0d want e1a0c00d@17", w1, v1);
        end
        vectors++;
        if (v2 !== 35 || w2 !== 32'h12345678) begin
            miscompares++;
            $display("FAIL b2b_second got %h@%0d want 12345678@35", w2, v2);
        end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset        = 1'b1;
        pcIn         = 32'd0;
        fetchReq     = 1'b0;
        flush        = 1'b0;
        rif.romReady = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b0;
        @(negedge clk);
        test_basic();
        test_unaligned();
        test_top_addr();
        test_flush();
        test_timeout();
        test_reset_mid();
        test_req_flush_idle();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Clocked instruction-fetch initiator driving the byte-wide ROM port (address, two-phase trigger, data, ready). On a request from the pipeline it issues four byte reads at a word-aligned PC and assembles them little-endian into a 32-bit ARM instruction. It hands the word to decode with a one-cycle valid pulse. It sits between the PC/branch logic and the ROM.

## Interface
- GUARD_CYCLES, 2: cycles after a trigger toggle before `romReady`/`romData` are trusted; range 1..15.
- TIMEOUT, 1000: maximum cycles spent in WAIT for one byte before aborting; 16-bit counter.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pcIn  in  32  fetch address; bits [1:0] ignored (word-aligned).
- fetchReq  in  1  level; sampled only in IDLE.
- flush  in  1  abandon current fetch (branch taken).
- fetchBusy  out  1  high in every state except IDLE.
- instrOut  out  32  last assembled instruction; holds between fetches.
- instrValid  out  1  one-cycle pulse when `instrOut` is updated.
- fetchErr  out  1  one-cycle pulse on timeout.
- romAddr  out  32  byte address to ROM; stable while `romTrigger` toggles.
- romTrigger  out  1  two-phase request: every toggle (either edge) is one read.
- romData  in  8  byte returned by ROM.
- romReady  in  1  ROM ready; passed through a 2-flop synchronizer (`readySync`).

## Operation
- The base address is `{pcIn[31:2],2'b00}`, latched in IDLE when `fetchReq` is high. Byte k (0..3) is read from base+k. There is no carry beyond bit 31; 0xFFFFFFFC..0xFFFFFFFF is legal.
- States:
  - IDLE: `fetchBusy`=0. If `fetchReq` && !`flush`, latch base, set `romAddr`=base and k=0, then go to ISSUE.
  - ISSUE: invert `romTrigger`, load the guard counter with GUARD_CYCLES, then go to GUARD.
  - GUARD: decrement the counter. At 0, clear the timeout counter and go to WAIT.
  - WAIT: if `readySync`=1, write `romData` into lane k (bits 8k+7:8k).
    - If k=3, go to DONE.
    - Otherwise set k=k+1 and `romAddr`=base+k+1, then go to ISSUE.
    - If `readySync`=0, increment the timeout counter. When it reaches TIMEOUT, pulse `fetchErr` and go to IDLE. `instrOut` is unchanged.
  - DONE: copy the assembly register to `instrOut`, pulse `instrValid`, then go to IDLE.
- Because `romAddr` is updated in WAIT and the toggle happens in ISSUE, the address has one full cycle of setup before each trigger edge.
- `flush` in any non-IDLE state forces IDLE on the next edge, with no `instrValid` and no `fetchErr`.
  - `romTrigger` keeps its level; no extra toggle is issued.
  - A late ROM response is ignored, and the GUARD of the next fetch absorbs it.
- `flush` during DONE does not retract that cycle's `instrValid`.
- `fetchReq` outside IDLE is ignored; the requester must still be holding it when the block is back in IDLE.
- `flush` and `fetchReq` together in IDLE: `flush` wins and no fetch starts.
- Reset, including mid-fetch, returns the block to IDLE with:
  - `romAddr`=0, `romTrigger`=0, `instrOut`=0, `instrValid`=0, `fetchBusy`=0, `fetchErr`=0;
  - the synchronizer, k and both counters cleared.
  - The resulting trigger edge to the ROM is harmless and is ignored.

## Timing
- All outputs are registered.
- Each byte costs 1 (ISSUE) + GUARD_CYCLES + 1 (WAIT) cycles when `readySync` is already 1.
- With request cycle = 0 and `romReady` high, `instrValid` is high in cycle 4·(GUARD_CYCLES+2)+1. That is cycle 17 at default parameters.
- Back-to-back fetches: the next `fetchReq` is sampled in the IDLE cycle after DONE. The request-to-request period is 4·(GUARD_CYCLES+2)+2 cycles.
- `romReady` low stretches WAIT cycle-for-cycle, plus 2 cycles of synchronizer delay.
- `fetchBusy` rises the cycle after the request is sampled. It falls in the cycle after DONE, timeout or flush.

## Test plan
- ROM at 0x100 holds 0D C0 A0 E1 and `pcIn`=0x100 with `fetchReq` held one cycle.
  - `instrOut`=0xE1A0C00D, `instrValid` pulses once in cycle 17.
  - `romAddr` sequence is 0x100..0x103.
  - `romTrigger` toggles exactly 4 times.
- `pcIn`=0x103 gives base 0x100 and the same result. `pcIn`=0xFFFFFFFC reads 0xFFFFFFFC..0xFFFFFFFF with no wrap to 0.
- `flush` pulsed after byte 1 is captured:
  - no `instrValid`, `instrOut` keeps its old value;
  - IDLE next cycle;
  - an immediate new fetch at 0x200 returns the correct word.
- `romReady` held low after the first toggle, with TIMEOUT=20: `fetchErr` pulses once after 20 WAIT cycles, then IDLE, with `instrValid` never set.
- `reset` asserted mid-WAIT of byte 2: all outputs go to reset values asynchronously, and a fetch after release completes normally.
- `fetchReq` and `flush` high together in IDLE: no fetch starts and `fetchBusy` stays 0.
